pio_in_edge_capture: RTL and testbench
======================================

// Module: pio_in_edge_capture
// PURPOSE
//  Avalon-MM slave input port: the fabric-to-HPS twin of the 4-bit output PIO.
//  Synchronises WIDTH status bits from fabric logic (e.g. mandelbrot frame_done)
//  and latches selected edges in a sticky edge-capture register.
//  Raises a maskable IRQ so HPS software can poll or take an interrupt.
//  Sits on the lightweight HPS bridge next to the output PIOs.
// PARAMETERS
//  WIDTH        4  number of input bits (1..32)
//  SYNC_STAGES  2  synchroniser flops on in_port (2..4)
//  EDGE_TYPE    0  capture edge: 0 rising, 1 falling, 2 any
//  IRQ_EDGE     1  1: irq from edgecapture&mask; 0: irq from level data&mask
// PORTS
//  clk        in   1      system clock; single clock domain
//  reset      in   1      synchronous, active-high reset
//  address    in   2      word address: 0 data, 1 rsvd, 2 irqmask, 3 edgecapture
//  chipselect in   1      slave select
//  write_n    in   1      active-low write strobe
//  writedata  in   32     write data; bits [WIDTH-1:0] used
//  readdata   out  32     read data, zero-extended from WIDTH
//  in_port    in   WIDTH  asynchronous fabric inputs
//  irq        out  1      level interrupt to HPS
// BEHAVIOUR
//  Reset (sync, high): sync chain, prev sample, irqmask, edgecapture, irq all 0.
//  Read latency 0: readdata is a combinational mux of address and registers.
//   addr0 = synced data; addr1 = 0; addr2 = irqmask; addr3 = edgecapture.
//  Write = chipselect & ~write_n.
//   addr2: irqmask <= writedata[WIDTH-1:0]. addr0/addr1: ignored.
//   addr3: write-1-to-clear. edgecapture[i] cleared where writedata[i]=1.
//  Data path: in_port -> SYNC_STAGES flops -> sync. addr0 shows a change
//   SYNC_STAGES cycles after in_port changes.
//  Edge detect: prev <= sync every cycle.
//   rise = sync&~prev; fall = ~sync&prev; select by EDGE_TYPE.
//   edgecapture[i] sets on the cycle after the edge appears on sync
//   (SYNC_STAGES+1 cycles after the in_port change). It stays set until cleared.
//  Arming: a counter suppresses edge capture for SYNC_STAGES+1 cycles after
//   reset deasserts, so reset-time levels never register as edges.
//   Assertion of reset mid-operation re-arms the counter.
//  Simultaneous set and clear on the same bit: set wins (bit stays 1).
//   Clears of other bits in the same write still apply.
//  irq is registered, 1 cycle after its source.
//   IRQ_EDGE=1: irq <= |(edgecapture & irqmask).
//   IRQ_EDGE=0: irq <= |(sync & irqmask).
//  Changing irqmask takes effect on irq 1 cycle after the write.
//  Unused high bits of readdata are always 0. No wait states. No error response.
// STRUCTURE
//  Shared package pio_pkg holds:
//   PIO_ADDR_DATA=0, PIO_ADDR_DIR=1, PIO_ADDR_MASK=2, PIO_ADDR_EDGE=3;
//   EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
//  Sub-module pio_sync_edge holds the per-vector synchroniser, prev register and
//   arming counter. Outputs: sync[WIDTH-1:0], edge[WIDTH-1:0].
//  The top level holds register file, read mux and irq.
// TESTING (WIDTH=4, SYNC_STAGES=2, EDGE_TYPE=0, IRQ_EDGE=1 unless noted)
//  1 Hold in_port=4'hF through reset, release -> edgecapture reads 0 forever;
//    addr0 reads 32'h0000000F from cycle 2 after release.
//  2 in_port 0->4'h5 at cycle t -> addr0=5 at t+2, addr3=5 at t+3;
//    irq stays 0 while irqmask=0.
//  3 Write irqmask=4'h1 with edgecapture=5 -> irq=1 next cycle.
//    Write addr3=4'h1 -> edgecapture=4, irq=0 next cycle.
//  4 Rising edge on bit2 arrives the same cycle as a write of addr3=4'h4 ->
//    edgecapture[2] stays 1.
//  5 EDGE_TYPE=2: in_port 4'h3->4'h1 -> edgecapture=4'h2.
//    IRQ_EDGE=0 with mask=4'h8: in_port bit3 high -> irq=1; bit3 low -> irq=0.
//  6 Assert reset mid-operation with edgecapture=4'hA, mask=4'hF ->
//    all registers 0 and irq=0 the next cycle.
//    No capture during the 3-cycle re-arm window.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared constants and bus payload types for the HPS-bridge PIO slaves.
package pio_pkg;

  localparam int unsigned PIO_DW = 32;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_DIR  = 2'd1;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  typedef struct packed {
    logic              en;
    logic [1:0]        addr;
    logic [PIO_DW-1:0] data;
  } pio_wr_t;

endpackage

// File: rtl/pio_sync_edge.sv
// Per-vector input synchroniser with edge detection, gated off until the
// synchroniser has flushed its reset contents.
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] edge_c
);

  localparam int unsigned ARM_MAX = SYNC_STAGES + 1;
  localparam int unsigned ARM_W   = $clog2(ARM_MAX + 1);

  logic [WIDTH-1:0] stage [SYNC_STAGES];
  logic [WIDTH-1:0] prev;
  logic [ARM_W-1:0] arm_cnt;
  logic             armed_c;
  logic [WIDTH-1:0] rise_c;
  logic [WIDTH-1:0] fall_c;
  logic [WIDTH-1:0] sel_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
      prev    <= '0;
      arm_cnt <= '0;
    end else begin
      stage[0] <= in_port;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
      prev <= sync;
      if (!armed_c) arm_cnt <= arm_cnt + ARM_W'(1);
    end
  end

  assign sync    = stage[SYNC_STAGES-1];
  assign armed_c = (arm_cnt == ARM_W'(ARM_MAX));

  // Edge qualification; levels present at reset release never count as edges
  always_comb begin
    rise_c = sync & ~prev;
    fall_c = ~sync & prev;
    sel_c  = rise_c;
    if (EDGE_TYPE == EDGE_FALL) begin
      sel_c = fall_c;
    end else if (EDGE_TYPE == EDGE_ANY) begin
      sel_c = rise_c | fall_c;
    end
    edge_c = armed_c ? sel_c : '0;
  end

endmodule

// File: rtl/pio_in_edge_capture.sv
// Avalon-MM input PIO: synchronised status bits, sticky edge capture with
// write-1-to-clear, and a maskable registered interrupt.
module pio_in_edge_capture
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE,
  parameter int unsigned IRQ_EDGE    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [PIO_DW-1:0] writedata,
  output logic [PIO_DW-1:0] readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  pio_wr_t          wr_c;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] edge_c;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] clr_c;
  logic             irq_src_c;
  logic             unused_wdata;

  pio_sync_edge #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .clk    (clk),
    .reset  (reset),
    .in_port(in_port),
    .sync   (sync),
    .edge_c (edge_c)
  );

  assign wr_c         = '{en: chipselect & ~write_n, addr: address, data: writedata};
  assign unused_wdata = ^wr_c.data;

  always_comb begin
    clr_c     = '0;
    irq_src_c = |(sync & irqmask);
    if (wr_c.en && (wr_c.addr == PIO_ADDR_EDGE)) clr_c = wr_c.data[WIDTH-1:0];
    if (IRQ_EDGE != 0) irq_src_c = |(edgecapture & irqmask);
  end

  // A new edge on a bit beats a same-cycle clear of that bit
  always_ff @(posedge clk) begin
    if (reset) begin
      irqmask     <= '0;
      edgecapture <= '0;
      irq         <= 1'b0;
    end else begin
      if (wr_c.en && (wr_c.addr == PIO_ADDR_MASK)) irqmask <= wr_c.data[WIDTH-1:0];
      edgecapture <= (edgecapture & ~clr_c) | edge_c;
      irq         <= irq_src_c;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      PIO_ADDR_DATA: readdata = PIO_DW'(sync);
      PIO_ADDR_DIR:  readdata = '0;
      PIO_ADDR_MASK: readdata = PIO_DW'(irqmask);
      PIO_ADDR_EDGE: readdata = PIO_DW'(edgecapture);
      default:       readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pio_in_edge_capture.sv
// Bench for pio_in_edge_capture: directed scenarios plus randomized traffic
// against a cycle-level reference model of the default configuration.
module tb_pio_in_edge_capture;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] readdata2;
  logic [3:0]  in_port;
  logic        irq;
  logic        irq2;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pio_in_edge_capture dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  pio_in_edge_capture #(.EDGE_TYPE(2), .IRQ_EDGE(0)) dut2 (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata2),
    .in_port(in_port), .irq(irq2)
  );

  // Reference model: in_port is seen S clocks late; rising edges of that
  // delayed view are latched once S+1 clocks have elapsed since reset.
  logic [3:0] hist[$];
  logic [3:0] m_sync, m_prev, m_mask, m_ec;
  logic       m_irq;
  int         since_rst;

  task automatic model_clock();
    logic [3:0] cap, clr;
    logic       wr_en;
    if (reset) begin
      hist = {};
      for (int i = 0; i < S; i++) hist.push_back(4'h0);
      m_sync = 4'h0; m_prev = 4'h0; m_mask = 4'h0; m_ec = 4'h0; m_irq = 1'b0;
      since_rst = 0;
    end else begin
      wr_en = chipselect && !write_n;
      m_irq = |(m_ec & m_mask);
      clr   = (wr_en && address == 2'd3) ? writedata[3:0] : 4'h0;
      cap   = (since_rst >= S + 1) ? (m_sync & ~m_prev) : 4'h0;
      m_ec  = (m_ec & ~clr) | cap;
      if (wr_en && address == 2'd2) m_mask = writedata[3:0];
      m_prev = m_sync;
      hist.push_front(in_port);
      void'(hist.pop_back());
      m_sync = hist[S-1];
      since_rst++;
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'h0, m_sync};
      2'd2:    return {28'h0, m_mask};
      2'd3:    return {28'h0, m_ec};
      default: return 32'h0;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d, output logic [31:0] d2);
    address = a;
    #1;
    d  = readdata;
    d2 = readdata2;
  endtask

  task automatic test_reset();
    logic [31:0] v, v2;
    reset = 1'b1; in_port = 4'hF; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd0; writedata = 32'h0;
    step(); step();
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v, v2);
      vectors++;
      if (v !== 32'h0) begin miscompares++; $display("FAIL reset_rd a=%0d got %h want %h", a, v, 32'h0); end
    end
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b want 0", irq); end
    reset = 1'b0;
    step();
    rd(2'd0, v, v2);
    vectors++;
    if (v !== 32'h0) begin miscompares++; $display("FAIL rel_c1_data got %h want %h", v, 32'h0); end
    step();
    rd(2'd0, v, v2);
    vectors++;
    if (v !== 32'hF) begin miscompares++; $display("FAIL rel_c2_data got %h want %h", v, 32'hF); end
    repeat (8) begin
      step();
      rd(2'd3, v, v2);
      vectors++;
      if (v !== 32'h0) begin miscompares++; $display("FAIL rel_no_edge got %h want %h", v, 32'h0); end
    end
  endtask

  task automatic test_rise_latency();
    logic [31:0] v, v2;
    in_port = 4'h0;
    repeat (4) step();
    rd(2'd3, v, v2);
    vectors++;
    if (v !== 32'h0) begin miscompares++; $display("FAIL fall_ignored got %h want %h", v, 32'h0); end
    in_port = 4'h5;
    step();
    rd(2'd0, v, v2);
    vectors++;
    if (v !== 32'h0) begin miscompares++; $display("FAIL lat_t1_data got %h want %h", v, 32'h0); end
    step();
    rd(2'd0, v, v2);
    vectors++;
    if (v !== 32'h5) begin miscompares++; $display("FAIL lat_t2_data got %h want %h", v, 32'h5); end
    rd(2'd3, v, v2);
    vectors++;
    if (v !== 32'h0) begin miscompares++; $display("FAIL lat_t2_edge got %h want %h", v, 32'h0); end
    step();
    rd(2'd3, v, v2);
    vectors++;
    if (v !== 32'h5) begin miscompares++; $display("FAIL lat_t3_edge got %h want %h", v, 32'h5); end
    repeat (3) begin
      step();
      vectors++;
      if (irq !== 1'b0) begin miscompares++; $display("FAIL masked_irq got %b want 0", irq); end
    end
  endtask

  task automatic test_irq_mask();
    logic [31:0] v, v2;
    wr(2'd2, 32'h1);
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL mask_wr_cycle got %b want 0", irq); end
    step();
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL mask_irq_set got %b want 1", irq); end
    wr(2'd3, 32'h1);
    rd(2'd3, v, v2);
    vectors++;
    if (v !== 32'h4) begin miscompares++; $display("FAIL w1c_edge got %h want %h", v, 32'h4); end
    step();
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL w1c_irq got %b want 0", irq); end
    rd(2'd2, v, v2);
    vectors++;
    if (v !== 32'h1) begin miscompares++; $display("FAIL mask_rd got %h want %h", v, 32'h1); end
  endtask

  task automatic test_set_wins();
    logic [31:0] v, v2;
    in_port = 4'h0;
    repeat (3) step();
    wr(2'd3, 32'hF);
    in_port = 4'h1;
    repeat (3) step();
    rd(2'd3, v, v2);
    vectors++;
    if (v !== 32'h1) begin miscompares++; $display("FAIL setup_bit0 got %h want %h", v, 32'h1); end
    in_port = 4'h5;
    step(); step();
    wr(2'd3, 32'h5);
    rd(2'd3, v, v2);
    vectors++;
    if (v !== 32'h4) begin miscompares++; $display("FAIL set_wins got %h want %h", v, 32'h4); end
    step();
    rd(2'd3, v, v2);
    vectors++;
    if (v !== 32'h4) begin miscompares++; $display("FAIL set_sticky got %h want %h", v, 32'h4); end
  endtask

  task automatic test_any_edge_level_irq();
    logic [31:0] v, v2;
    reset = 1'b1; in_port = 4'h3;
    step(); step();
    reset = 1'b0;
    repeat (5) step();
    in_port = 4'h1;
    repeat (3) step();
    rd(2'd3, v, v2);
    vectors++;
    if (v2 !== 32'h2) begin miscompares++; $display("FAIL any_edge got %h want %h", v2, 32'h2); end
    wr(2'd2, 32'h8);
    in_port = 4'h9;
    step(); step();
    vectors++;
    if (irq2 !== 1'b0) begin miscompares++; $display("FAIL lvl_irq_early got %b want 0", irq2); end
    step();
    vectors++;
    if (irq2 !== 1'b1) begin miscompares++; $display("FAIL lvl_irq_high got %b want 1", irq2); end
    in_port = 4'h1;
    step(); step();
    vectors++;
    if (irq2 !== 1'b1) begin miscompares++; $display("FAIL lvl_irq_hold got %b want 1", irq2); end
    step();
    vectors++;
    if (irq2 !== 1'b0) begin miscompares++; $display("FAIL lvl_irq_low got %b want 0", irq2); end
  endtask

  task automatic test_midop_reset();
    logic [31:0] v, v2;
    in_port = 4'h0;
    repeat (3) step();
    wr(2'd3, 32'hF);
    wr(2'd2, 32'hF);
    in_port = 4'hA;
    repeat (3) step();
    rd(2'd3, v, v2);
    vectors++;
    if (v !== 32'hA) begin miscompares++; $display("FAIL pre_rst_edge got %h want %h", v, 32'hA); end
    step();
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL pre_rst_irq got %b want 1", irq); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v, v2);
      vectors++;
      if (v !== 32'h0) begin miscompares++; $display("FAIL midrst_rd a=%0d got %h want %h", a, v, 32'h0); end
    end
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL midrst_irq got %b want 0", irq); end
    repeat (6) begin
      step();
      rd(2'd3, v, v2);
      vectors++;
      if (v !== 32'h0) begin miscompares++; $display("FAIL rearm_window got %h want %h", v, 32'h0); end
    end
    in_port = 4'h0;
    repeat (3) step();
    in_port = 4'hA;
    repeat (3) step();
    rd(2'd3, v, v2);
    vectors++;
    if (v !== 32'hA) begin miscompares++; $display("FAIL post_arm_edge got %h want %h", v, 32'hA); end
  endtask

  task automatic test_random();
    logic [31:0] v, v2, exp;
    logic [1:0]  ra;
    int          op;
    for (int n = 0; n < 500; n++) begin
      reset = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 2) == 0) in_port = 4'($urandom);
      op = $urandom_range(0, 5);
      chipselect = (op < 3) || (op == 4);
      write_n    = (op >= 3);
      if (op == 5) write_n = 1'b0;
      address   = 2'($urandom);
      writedata = $urandom;
      step();
      chipselect = 1'b0; write_n = 1'b1;
      ra = 2'($urandom);
      rd(ra, v, v2);
      exp = m_read(ra);
      vectors++;
      if (v !== exp) begin miscompares++; $display("FAIL rand_rd n=%0d a=%0d got %h want %h", n, ra, v, exp); end
      vectors++;
      if (irq !== m_irq) begin miscompares++; $display("FAIL rand_irq n=%0d got %b want %b", n, irq, m_irq); end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rise_latency();
    test_irq_mask();
    test_set_wins();
    test_any_edge_level_irq();
    test_midop_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
